// File: rtl/fc_layer_seq.sv
// Time-multiplexed fully-connected layer: buffers one input vector, then computes LANES neurons
// per pass over external weight/bias memories and streams rescaled, saturated results out.
module fc_layer_seq #(
  parameter int unsigned IN_SIZE  = 784,
  parameter int unsigned OUT_SIZE = 128,
  parameter int unsigned LANES    = 4,
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned FRAC_W   = 8,
  parameter int unsigned ACC_W    = 2 * DATA_W + $clog2(IN_SIZE) + 1,
  parameter bit          RELU_EN  = 1'b1,
  localparam int unsigned NG      = OUT_SIZE / LANES,
  localparam int unsigned WA_W    = $clog2(NG * IN_SIZE),
  localparam int unsigned GA_W    = (NG > 1) ? $clog2(NG) : 1,
  localparam int unsigned IDX_W   = (OUT_SIZE > 1) ? $clog2(OUT_SIZE) : 1
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [DATA_W-1:0]         in_data_i,
  output logic                      w_rd_o,
  output logic [WA_W-1:0]           w_addr_o,
  input  logic [LANES*DATA_W-1:0]   w_data_i,
  output logic                      b_rd_o,
  output logic [GA_W-1:0]           b_addr_o,
  input  logic [LANES*DATA_W-1:0]   b_data_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [DATA_W-1:0]         out_data_o,
  output logic [IDX_W-1:0]          out_idx_o,
  output logic                      out_last_o,
  output logic                      busy_o
);

  localparam int unsigned J_W = $clog2(IN_SIZE);
  localparam int unsigned K_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

  typedef enum logic [2:0] {StIdle, StLoad, StCompute, StDrain, StOutput} state_e;

  state_e                   state_q, state_d;
  logic [J_W-1:0]           cnt_q, cnt_d;
  logic [WA_W-1:0]          waddr_q, waddr_d;
  logic [GA_W-1:0]          g_q, g_d;
  logic [K_W-1:0]           k_q, k_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     mac_vld_q, mac_vld_d;
  logic                     mac_first_q, mac_first_d;
  logic [J_W-1:0]           mac_j_q, mac_j_d;
  logic signed [ACC_W-1:0]  acc_q [LANES];
  logic signed [ACC_W-1:0]  acc_d [LANES];
  logic [DATA_W-1:0]        res_q [LANES];
  logic [DATA_W-1:0]        res_d [LANES];
  logic signed [DATA_W-1:0] ibuf_q [IN_SIZE];

  logic signed [DATA_W-1:0]   w_lane [LANES];
  logic signed [DATA_W-1:0]   b_lane [LANES];
  logic signed [2*DATA_W-1:0] prod [LANES];
  logic signed [ACC_W-1:0]    prod_ext [LANES];
  logic signed [ACC_W-1:0]    bias_ext [LANES];
  logic signed [ACC_W-1:0]    shr [LANES];

  logic in_acc, out_fire;
  assign in_acc   = in_valid_i && in_ready_o;
  assign out_fire = out_valid_o && out_ready_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      waddr_q     <= '0;
      g_q         <= '0;
      k_q         <= '0;
      idx_q       <= '0;
      mac_vld_q   <= 1'b0;
      mac_first_q <= 1'b0;
      mac_j_q     <= '0;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= '0;
        res_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      waddr_q     <= waddr_d;
      g_q         <= g_d;
      k_q         <= k_d;
      idx_q       <= idx_d;
      mac_vld_q   <= mac_vld_d;
      mac_first_q <= mac_first_d;
      mac_j_q     <= mac_j_d;
      for (int k = 0; k < LANES; k++) begin
        acc_q[k] <= acc_d[k];
        res_q[k] <= res_d[k];
      end
    end
  end

  // Input buffer holds data only; it needs no reset.
  always_ff @(posedge clk_i) begin
    if (in_acc) ibuf_q[cnt_q] <= in_data_i;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:    if (in_acc) state_d = StLoad;
      StLoad:    if (in_acc && cnt_q == J_W'(IN_SIZE - 1)) state_d = StCompute;
      StCompute: if (cnt_q == J_W'(IN_SIZE - 1)) state_d = StDrain;
      StDrain:   state_d = StOutput;
      StOutput: begin
        if (out_fire && k_q == K_W'(LANES - 1)) begin
          state_d = (g_q == GA_W'(NG - 1)) ? StIdle : StCompute;
        end
      end
      default:   state_d = StIdle;
    endcase
  end

  always_comb begin
    cnt_d       = cnt_q;
    waddr_d     = waddr_q;
    g_d         = g_q;
    k_d         = k_q;
    idx_d       = idx_q;
    mac_vld_d   = 1'b0;
    mac_first_d = 1'b0;
    mac_j_d     = cnt_q;
    if (state_q == StIdle) begin
      waddr_d = '0;
      g_d     = '0;
      k_d     = '0;
      idx_d   = '0;
    end
    unique case (state_q)
      StIdle, StLoad: begin
        if (in_acc) cnt_d = (cnt_q == J_W'(IN_SIZE - 1)) ? '0 : cnt_q + 1'b1;
      end
      StCompute: begin
        // Memory data returns next cycle, so the MAC runs one cycle behind the read.
        mac_vld_d   = 1'b1;
        mac_first_d = (cnt_q == '0);
        waddr_d     = waddr_q + 1'b1;
        cnt_d       = (cnt_q == J_W'(IN_SIZE - 1)) ? '0 : cnt_q + 1'b1;
      end
      StOutput: begin
        if (out_fire) begin
          idx_d = idx_q + 1'b1;
          if (k_q == K_W'(LANES - 1)) begin
            k_d = '0;
            g_d = g_q + 1'b1;
          end else begin
            k_d = k_q + 1'b1;
          end
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    for (int k = 0; k < LANES; k++) begin
      w_lane[k]   = w_data_i[k*DATA_W +: DATA_W];
      b_lane[k]   = b_data_i[k*DATA_W +: DATA_W];
      prod[k]     = w_lane[k] * ibuf_q[mac_j_q];
      prod_ext[k] = {{(ACC_W-2*DATA_W){prod[k][2*DATA_W-1]}}, prod[k]};
      bias_ext[k] = {{(ACC_W-DATA_W){b_lane[k][DATA_W-1]}}, b_lane[k]} <<< FRAC_W;
      acc_d[k]    = acc_q[k];
      if (mac_vld_q) acc_d[k] = (mac_first_q ? bias_ext[k] : acc_q[k]) + prod_ext[k];
      shr[k] = acc_d[k] >>> FRAC_W;
      if (RELU_EN && shr[k][ACC_W-1]) shr[k] = '0;
      res_d[k] = res_q[k];
      if (state_q == StDrain) begin
        if (shr[k] > SatMax)      res_d[k] = SatMax[DATA_W-1:0];
        else if (shr[k] < SatMin) res_d[k] = SatMin[DATA_W-1:0];
        else                      res_d[k] = shr[k][DATA_W-1:0];
      end
    end
  end

  always_comb begin
    in_ready_o  = (state_q == StIdle || state_q == StLoad) && !rst_i;
    w_rd_o      = (state_q == StCompute);
    w_addr_o    = w_rd_o ? waddr_q : '0;
    b_rd_o      = w_rd_o && (cnt_q == '0);
    b_addr_o    = b_rd_o ? g_q : '0;
    out_valid_o = (state_q == StOutput);
    out_data_o  = out_valid_o ? res_q[k_q] : '0;
    out_idx_o   = out_valid_o ? idx_q : '0;
    out_last_o  = out_valid_o && (idx_q == IDX_W'(OUT_SIZE - 1));
    busy_o      = (state_q != StIdle);
  end

endmodule

// File: tb/tb_fc_layer_seq.sv
// Directed bench for fc_layer_seq: two instances (ReLU on/off) share stimulus and run in lockstep.
module tb_fc_layer_seq;
  localparam int unsigned IN_SIZE  = 4;
  localparam int unsigned OUT_SIZE = 4;
  localparam int unsigned LANES    = 2;

  typedef logic [15:0] vec_t [4];
  typedef int tvec_t [4];

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_data = '0;
  logic        out_ready = 1'b1;

  logic        in_ready_r, w_rd_r, b_rd_r, out_valid_r, out_last_r, busy_r;
  logic        in_ready_n, w_rd_n, b_rd_n, out_valid_n, out_last_n, busy_n;
  logic [2:0]  w_addr_r, w_addr_n;
  logic [0:0]  b_addr_r, b_addr_n;
  logic [31:0] w_data_r, w_data_n, b_data_r, b_data_n;
  logic [15:0] out_data_r, out_data_n;
  logic [1:0]  out_idx_r, out_idx_n;

  logic [31:0] wmem [8];
  logic [31:0] bmem [2];
  int errors = 0;
  int checks = 0;
  int cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    if (w_rd_r) w_data_r <= wmem[w_addr_r];
    if (b_rd_r) b_data_r <= bmem[b_addr_r];
    if (w_rd_n) w_data_n <= wmem[w_addr_n];
    if (b_rd_n) b_data_n <= bmem[b_addr_n];
  end

  fc_layer_seq #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .LANES(LANES), .DATA_W(16), .FRAC_W(8),
                 .RELU_EN(1'b1)) dut_r (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_r), .in_data_i(in_data),
    .w_rd_o(w_rd_r), .w_addr_o(w_addr_r), .w_data_i(w_data_r), .b_rd_o(b_rd_r),
    .b_addr_o(b_addr_r), .b_data_i(b_data_r), .out_valid_o(out_valid_r), .out_ready_i(out_ready),
    .out_data_o(out_data_r), .out_idx_o(out_idx_r), .out_last_o(out_last_r), .busy_o(busy_r)
  );

  fc_layer_seq #(.IN_SIZE(IN_SIZE), .OUT_SIZE(OUT_SIZE), .LANES(LANES), .DATA_W(16), .FRAC_W(8),
                 .RELU_EN(1'b0)) dut_n (
    .clk_i(clk), .rst_i(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_n), .in_data_i(in_data),
    .w_rd_o(w_rd_n), .w_addr_o(w_addr_n), .w_data_i(w_data_n), .b_rd_o(b_rd_n),
    .b_addr_o(b_addr_n), .b_data_i(b_data_n), .out_valid_o(out_valid_n), .out_ready_i(out_ready),
    .out_data_o(out_data_n), .out_idx_o(out_idx_n), .out_last_o(out_last_n), .busy_o(busy_n)
  );

  function automatic logic [31:0] outs_r();
    return {4'b0, in_ready_r, w_rd_r, w_addr_r, b_rd_r, b_addr_r, out_valid_r, out_data_r,
            out_idx_r, out_last_r, busy_r};
  endfunction

  function automatic logic [31:0] outs_n();
    return {4'b0, in_ready_n, w_rd_n, w_addr_n, b_rd_n, b_addr_n, out_valid_n, out_data_n,
            out_idx_n, out_last_n, busy_n};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    checks++;
    assert (obs === want) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  task automatic set_uniform(input logic [15:0] w, input logic [15:0] b);
    for (int a = 0; a < 8; a++) wmem[a] = {w, w};
    for (int a = 0; a < 2; a++) bmem[a] = {b, b};
  endtask

  task automatic send_frame(input vec_t x, output int t_first, output int t_last);
    int n;
    t_first = 0;
    t_last  = 0;
    for (int i = 0; i < IN_SIZE; i++) begin
      in_valid = 1'b1;
      in_data  = x[i];
      n = 0;
      while (!in_ready_r && n < 200) begin
        @(negedge clk);
        n++;
      end
      if (!in_ready_r) begin
        check("in_accept_timeout", {31'b0, in_ready_r}, 32'd1);
        in_valid = 1'b0;
        return;
      end
      if (i == 0) t_first = cyc;
      if (i == IN_SIZE - 1) t_last = cyc;
      @(negedge clk);
    end
    in_valid = 1'b0;
  endtask

  // mode 0: out_ready held high; mode 1: 5-cycle stall on idx 1, random ready elsewhere
  task automatic collect(input int first, input int num, input vec_t exp_r, input vec_t exp_n,
                         input int mode, output tvec_t tv, output int t_done);
    int n, vcnt;
    logic got;
    t_done = 0;
    for (int i = 0; i < 4; i++) tv[i] = 0;
    for (int i = first; i < first + num; i++) begin
      n = 0;
      vcnt = 0;
      got = 1'b0;
      while (!got && n < 100) begin
        if (mode == 1) begin
          if (i == 1 && vcnt < 5) out_ready = 1'b0;
          else if (i == 0) out_ready = 1'b1;
          else out_ready = 1'($urandom_range(0, 1));
        end else begin
          out_ready = 1'b1;
        end
        if (out_valid_r) begin
          if (vcnt == 0) begin
            tv[i] = cyc;
            check($sformatf("data_relu[%0d]", i), out_data_r, exp_r[i]);
            check($sformatf("data_norelu[%0d]", i), out_data_n, exp_n[i]);
            check($sformatf("idx[%0d]", i), out_idx_r, i);
            check($sformatf("last[%0d]", i), out_last_r, (i == OUT_SIZE - 1));
            check($sformatf("valid_norelu[%0d]", i), out_valid_n, 1);
          end else begin
            check($sformatf("stall_data[%0d]", i), out_data_r, exp_r[i]);
            check($sformatf("stall_idx[%0d]", i), out_idx_r, i);
          end
          if (mode == 1) check($sformatf("no_rd_in_output[%0d]", i), w_rd_r, 0);
          vcnt++;
          if (out_ready) begin
            got = 1'b1;
            t_done = cyc;
          end
        end
        @(negedge clk);
        n++;
      end
      if (!got) check($sformatf("out_timeout[%0d]", i), {31'b0, got}, 32'd1);
    end
    out_ready = 1'b1;
  endtask

  initial begin
    vec_t  x_one, x_two, x_max, x_mix, e_200, e_400, e_max, e_min_r, e_min_n, e_fc_r, e_fc_n;
    vec_t  e_mix_r, e_mix_n;
    tvec_t tv;
    int    t_first, t_last, t_done, t_first2, t_last2, n;

    x_one   = '{16'h0100, 16'h0100, 16'h0100, 16'h0100};
    x_two   = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    x_max   = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    x_mix   = '{16'h0001, 16'h0100, 16'h0200, 16'hFF00};
    e_200   = '{16'h0200, 16'h0200, 16'h0200, 16'h0200};
    e_400   = '{16'h0400, 16'h0400, 16'h0400, 16'h0400};
    e_max   = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF};
    e_min_r = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    e_min_n = '{16'h8000, 16'h8000, 16'h8000, 16'h8000};
    e_fc_r  = '{16'h0000, 16'h0000, 16'h0000, 16'h0000};
    e_fc_n  = '{16'hFC80, 16'hFC80, 16'hFC80, 16'hFC80};
    e_mix_r = '{16'h0000, 16'h0300, 16'h0000, 16'h0280};
    e_mix_n = '{16'hFFFF, 16'h0300, 16'hFE80, 16'h0280};

    // Reset behaviour
    #1 rst = 1'b1;
    #2;
    check("reset_outs_relu", outs_r(), 32'h0);
    check("reset_outs_norelu", outs_n(), 32'h0);
    repeat (2) @(negedge clk);
    check("reset_held_outs", outs_r(), 32'h0);
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_reset", in_ready_r, 1);
    check("busy_after_reset", busy_r, 0);

    // Basic MAC with latency and read-strobe checks
    set_uniform(16'h0080, 16'h0000);
    send_frame(x_one, t_first, t_last);
    check("j0_w_rd", w_rd_r, 1);
    check("j0_b_rd", b_rd_r, 1);
    check("j0_w_addr", w_addr_r, 0);
    check("j0_busy", busy_r, 1);
    @(negedge clk);
    check("j1_b_rd", b_rd_r, 0);
    check("j1_w_addr", w_addr_r, 1);
    check("j1_in_ready", in_ready_r, 0);
    collect(0, 4, e_200, e_200, 0, tv, t_done);
    check("latency_first_valid", tv[0] - t_last, 6);
    check("group_period", tv[2] - tv[0], IN_SIZE + 1 + LANES);
    check("idle_after_frame", busy_r, 0);

    // Saturation, both signs
    set_uniform(16'h7FFF, 16'h7FFF);
    send_frame(x_max, t_first, t_last);
    collect(0, 4, e_max, e_max, 0, tv, t_done);
    set_uniform(16'h8000, 16'h0000);
    send_frame(x_max, t_first, t_last);
    collect(0, 4, e_min_r, e_min_n, 0, tv, t_done);

    // ReLU and truncation
    set_uniform(16'hFF00, 16'h0080);
    send_frame(x_one, t_first, t_last);
    collect(0, 4, e_fc_r, e_fc_n, 0, tv, t_done);

    // Per-neuron weights: lane packing, address order, acc = -1 rounding
    wmem[0] = {16'h0000, 16'hFFFF}; wmem[1] = {16'h0100, 16'h0000};
    wmem[2] = {16'h0100, 16'h0000}; wmem[3] = {16'h0100, 16'h0000};
    wmem[4] = {16'h0100, 16'h0000}; wmem[5] = {16'h0000, 16'h0080};
    wmem[6] = {16'h0140, 16'h0000}; wmem[7] = {16'h0000, 16'h0200};
    bmem[0] = {16'h0100, 16'h0000}; bmem[1] = {16'hFFFF, 16'h0000};
    send_frame(x_mix, t_first, t_last);
    collect(0, 4, e_mix_r, e_mix_n, 0, tv, t_done);

    // Backpressure on the same data
    send_frame(x_mix, t_first, t_last);
    collect(0, 4, e_mix_r, e_mix_n, 1, tv, t_done);

    // Reset during group 1, j=2
    set_uniform(16'h0080, 16'h0000);
    send_frame(x_one, t_first, t_last);
    collect(0, 2, e_200, e_200, 0, tv, t_done);
    n = 0;
    while (!(w_rd_r && w_addr_r == 3'd6) && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("reach_g1_j2", {31'b0, w_rd_r}, 32'd1);
    check("g1_b_rd_off", b_rd_r, 0);
    #1 rst = 1'b1;
    #1;
    check("midrst_outs_relu", outs_r(), 32'h0);
    check("midrst_outs_norelu", outs_n(), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready_r, 1);
    check("midrst_busy", busy_r, 0);
    send_frame(x_one, t_first, t_last);
    collect(0, 4, e_200, e_200, 0, tv, t_done);

    // Back-to-back: second frame presented continuously while the first drains
    send_frame(x_one, t_first, t_last);
    fork
      collect(0, 4, e_200, e_200, 0, tv, t_done);
      send_frame(x_two, t_first2, t_last2);
    join
    check("b2b_first_accept", t_first2, t_done + 1);
    collect(0, 4, e_400, e_400, 0, tv, t_done);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end
endmodule
